fifo_rd_arbiter: RTL and testbench
==================================

FIFO_RD_ARBITER -- requirements
Module: fifo_rd_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, giving the width of the source and transmit data words.
REQ-002 SHALL have parameter BURST_MAX, default 4, giving the maximum words popped per grant; legal range 1..15.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port arb_en, input, 1 bit: enables new grants.
REQ-006 SHALL have port src0_empty, input, 1 bit: source 0 FIFO read-side empty flag.
REQ-007 SHALL have port src0_rd_data, input, DATA_WIDTH bits: source 0 FIFO head word, valid while src0_empty=0.
REQ-008 SHALL have port src0_rd_inc, output, 1 bit: source 0 pop strobe; the pointer advances on the same CLK edge.
REQ-009 SHALL have ports src1_empty, src1_rd_data and src1_rd_inc, identical to REQ-006..008 for source 1.
REQ-010 SHALL have port tx_ready, input, 1 bit: consumer accepts tx_data when tx_ready=1 and tx_valid=1.
REQ-011 SHALL have port tx_data, output, DATA_WIDTH bits, registered: the word offered to the consumer.
REQ-012 SHALL have port tx_valid, output, 1 bit, registered: tx_data holds an unaccepted word.
REQ-013 SHALL have port grant_vld, output, 1 bit, registered: a source is currently granted.
REQ-014 SHALL have port grant_id, output, 1 bit, registered: index of the granted or last granted source.

Function
REQ-015 SHALL implement FSM states IDLE and SERVE, plus a 4-bit burst counter and a 1-bit last_src register.
REQ-016 In IDLE with arb_en=1, SHALL grant on the next edge:
- the only non-empty source, if exactly one is non-empty;
- source ~last_src, if both are non-empty (round robin).
On a grant: grant_id and last_src take the granted index, grant_vld=1, burst counter=0, state becomes SERVE.
REQ-017 In IDLE with arb_en=0 or both sources empty, SHALL remain in IDLE with grant_vld=0.
REQ-018 Output register free is defined as (tx_valid=0) or (tx_ready=1).
REQ-019 In SERVE, when the granted source is non-empty and the output register is free, SHALL, in the same cycle:
- assert that source's rd_inc combinationally;
- load tx_data with its rd_data on the edge;
- set tx_valid=1;
- increment the burst counter.
REQ-020 The non-granted source's rd_inc SHALL be 0 at all times; both rd_inc SHALL be 0 in IDLE and whenever RST=1.
REQ-021 On a pop with burst counter equal to BURST_MAX-1, SHALL return to IDLE with grant_vld=0 (burst limit release).
REQ-022 In SERVE with the granted source empty, SHALL pop nothing and return to IDLE with grant_vld=0 (empty release).
REQ-023 In SERVE with arb_en=0, SHALL complete the pop of the current cycle, if one qualifies, then return to IDLE.
REQ-024 When tx_ready=1, tx_valid=1 and no pop occurs, SHALL clear tx_valid; when a pop coincides with acceptance, tx_valid SHALL stay 1 with new data.
REQ-025 While tx_valid=1 and tx_ready=0, tx_data SHALL hold stable and no pop SHALL occur.
REQ-026 Sustained throughput SHALL be one word per cycle while the granted source is non-empty and tx_ready=1.
REQ-027 Latency SHALL be 1 cycle from the grant edge to the first pop, and the popped word SHALL appear on tx_data with tx_valid=1 one edge after its pop.
REQ-028 SHALL never pop an empty source and never drop or duplicate a word.

Reset
REQ-029 With RST=1 at an edge, SHALL set state=IDLE, tx_valid=0, tx_data=0, grant_vld=0, grant_id=0, burst counter=0 and last_src=1 (source 0 wins the first contention).
REQ-030 Reset asserted mid-burst SHALL discard the pending tx_data word; FIFO contents not yet popped SHALL be unaffected.

Verification
REQ-031 Contention test: src0 holds A0..A5 and src1 holds B0..B1, tx_ready=1, arb_en=1 after reset -> tx order SHALL be A0 A1 A2 A3 B0 B1 A4 A5, with grant_id sequence 0,1,0.
REQ-032 Backpressure test: single source holds 3 words and tx_ready=0 for 5 cycles after the first load -> tx_data SHALL stay at word 0, no rd_inc pulses occur, then 3 words are accepted in 3 consecutive cycles.
REQ-033 Empty release test: src1 holds 2 words and BURST_MAX=4 -> after 2 pops the FSM SHALL return to IDLE via empty release with grant_vld=0.
REQ-034 Enable test: arb_en deasserted in the second SERVE cycle with src0 holding 4 words -> exactly 2 words SHALL be popped and no further grant occurs until arb_en=1.
REQ-035 Reset test: RST pulsed mid-burst with tx_valid=1 -> the next cycle SHALL show tx_valid=0, grant_vld=0, both rd_inc=0, and the next contention is granted to source 0.
REQ-036 Pop/accept overlap test: continuous tx_ready=1 over 8 words -> tx_valid SHALL stay 1 without gaps inside each burst, and the rd_inc pulse count SHALL equal the accepted word count.

Source files
------------

// File: rtl/fifo_rd_arbiter_if.sv
// Bus bundle between the two-source FIFO read arbiter and its sources/consumer.
interface fifo_rd_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  arb_en;
  logic                  src0_empty;
  logic [DATA_WIDTH-1:0] src0_rd_data;
  logic                  src0_rd_inc;
  logic                  src1_empty;
  logic [DATA_WIDTH-1:0] src1_rd_data;
  logic                  src1_rd_inc;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  grant_vld;
  logic                  grant_id;

  modport master (
    input  arb_en, src0_empty, src0_rd_data, src1_empty, src1_rd_data, tx_ready,
    output src0_rd_inc, src1_rd_inc, tx_data, tx_valid, grant_vld, grant_id
  );

  modport slave (
    output arb_en, src0_empty, src0_rd_data, src1_empty, src1_rd_data, tx_ready,
    input  src0_rd_inc, src1_rd_inc, tx_data, tx_valid, grant_vld, grant_id
  );
endinterface

// File: rtl/fifo_rd_arbiter.sv
// Round-robin burst arbiter popping two FIFO read ports into one registered
// valid/ready transmit stage.
module fifo_rd_arbiter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BURST_MAX  = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  fifo_rd_arbiter_if.master     arb_bus
);

  localparam int unsigned CNT_W    = 4;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_MAX - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_burst, w_burst_nxt;
  logic                  r_last_src, w_last_src_nxt;
  logic                  r_grant_vld, w_grant_vld_nxt;
  logic                  r_grant_id, w_grant_id_nxt;
  logic                  r_tx_valid, w_tx_valid_nxt;
  logic [DATA_WIDTH-1:0] r_tx_data, w_tx_data_nxt;
  logic                  w_free;
  logic                  w_sel_empty;
  logic                  w_pop;

  // Next-state, grant selection and pop decision
  always_comb begin
    w_state_nxt     = r_state;
    w_burst_nxt     = r_burst;
    w_last_src_nxt  = r_last_src;
    w_grant_id_nxt  = r_grant_id;
    w_tx_valid_nxt  = r_tx_valid;
    w_tx_data_nxt   = r_tx_data;
    w_grant_vld_nxt = 1'b0;
    w_pop           = 1'b0;
    w_free          = !r_tx_valid || arb_bus.tx_ready;
    w_sel_empty     = r_grant_id ? arb_bus.src1_empty : arb_bus.src0_empty;

    case (r_state)
      IDLE: begin
        if (arb_bus.arb_en && !(arb_bus.src0_empty && arb_bus.src1_empty)) begin
          // Both non-empty: alternate; otherwise the non-empty one (src0 empty -> 1)
          w_grant_id_nxt = (!arb_bus.src0_empty && !arb_bus.src1_empty) ?
                           ~r_last_src : arb_bus.src0_empty;
          w_last_src_nxt = w_grant_id_nxt;
          w_burst_nxt    = '0;
          w_state_nxt    = SERVE;
        end
      end
      SERVE: begin
        w_pop = !w_sel_empty && w_free && !RST;
        if (w_pop) begin
          w_burst_nxt = r_burst + CNT_W'(1);
        end
        if (w_sel_empty || !arb_bus.arb_en || (w_pop && (r_burst == LAST_CNT))) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    if (w_pop) begin
      w_tx_valid_nxt = 1'b1;
      w_tx_data_nxt  = r_grant_id ? arb_bus.src1_rd_data : arb_bus.src0_rd_data;
    end else if (arb_bus.tx_ready) begin
      w_tx_valid_nxt = 1'b0;
    end

    w_grant_vld_nxt = (w_state_nxt == SERVE);
  end

  // State and output registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= IDLE;
      r_burst     <= '0;
      r_last_src  <= 1'b1;
      r_grant_vld <= 1'b0;
      r_grant_id  <= 1'b0;
      r_tx_valid  <= 1'b0;
      r_tx_data   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_burst     <= w_burst_nxt;
      r_last_src  <= w_last_src_nxt;
      r_grant_vld <= w_grant_vld_nxt;
      r_grant_id  <= w_grant_id_nxt;
      r_tx_valid  <= w_tx_valid_nxt;
      r_tx_data   <= w_tx_data_nxt;
    end
  end

  assign arb_bus.src0_rd_inc = w_pop && !r_grant_id;
  assign arb_bus.src1_rd_inc = w_pop &&  r_grant_id;
  assign arb_bus.tx_data     = r_tx_data;
  assign arb_bus.tx_valid    = r_tx_valid;
  assign arb_bus.grant_vld   = r_grant_vld;
  assign arb_bus.grant_id    = r_grant_id;

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Randomized bench for fifo_rd_arbiter: queue-backed source FIFOs, a
// transaction-level arbitration model and an in-order word scoreboard.
module tb_fifo_rd_arbiter;

  localparam int unsigned DW = 8;
  localparam int unsigned BM = 4;

  logic clk;
  logic rst;

  fifo_rd_arbiter_if #(.DATA_WIDTH(DW)) bus ();

  fifo_rd_arbiter #(.DATA_WIDTH(DW), .BURST_MAX(BM)) u_dut (
    .CLK     (clk),
    .RST     (rst),
    .arb_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned pulses = 0;

  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  logic [DW-1:0] sb[$];
  logic [DW-1:0] acc_log[$];
  bit            glog[$];
  bit            prev_gv = 1'b0;

  // Model: which source (if any) owns the bus, words taken in this grant, output stage
  bit            m_serving = 1'b0;
  int            m_taken   = 0;
  bit            m_gid     = 1'b0;
  bit            m_last    = 1'b1;
  bit            m_tv      = 1'b0;
  logic [DW-1:0] m_td      = '0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic cycle(input bit r, input bit en, input bit rdy);
    bit            e0, e1, free, src_empty, pop;
    logic [DW-1:0] w;
    @(negedge clk);
    check("tx_valid",  32'(bus.tx_valid),  32'(m_tv));
    check("tx_data",   32'(bus.tx_data),   32'(m_td));
    check("grant_vld", 32'(bus.grant_vld), 32'(m_serving));
    check("grant_id",  32'(bus.grant_id),  32'(m_gid));
    if (bus.grant_vld && !prev_gv) glog.push_back(bus.grant_id);
    prev_gv = bus.grant_vld;
    if (!r && bus.tx_valid && rdy) begin
      check("accept_pending", 32'(sb.size() != 0), 32'(1));
      if (sb.size() != 0) begin
        check("accept_word", 32'(bus.tx_data), 32'(sb.pop_front()));
        acc_log.push_back(bus.tx_data);
      end
    end
    e0 = (q0.size() == 0);
    e1 = (q1.size() == 0);
    rst              = r;
    bus.arb_en       = en;
    bus.tx_ready     = rdy;
    bus.src0_empty   = e0;
    bus.src1_empty   = e1;
    bus.src0_rd_data = e0 ? 8'hEE : q0[0];
    bus.src1_rd_data = e1 ? 8'hEE : q1[0];
    #1;
    pop = 1'b0;
    w   = '0;
    if (r) begin
      m_serving = 1'b0; m_taken = 0; m_gid = 1'b0; m_last = 1'b1;
      m_tv = 1'b0; m_td = '0;
    end else begin
      free = !m_tv || rdy;
      if (m_serving) begin
        src_empty = m_gid ? e1 : e0;
        pop = !src_empty && free;
        if (pop) begin
          w = m_gid ? q1[0] : q0[0];
          m_taken++;
        end
        if (src_empty || !en || m_taken == int'(BM)) m_serving = 1'b0;
      end else if (en && !(e0 && e1)) begin
        m_gid     = (!e0 && !e1) ? !m_last : e0;
        m_last    = m_gid;
        m_serving = 1'b1;
        m_taken   = 0;
      end
      if (pop) begin
        m_tv = 1'b1;
        m_td = w;
      end else if (rdy) begin
        m_tv = 1'b0;
      end
    end
    check("rd_inc0", 32'(bus.src0_rd_inc), 32'(pop && !m_gid));
    check("rd_inc1", 32'(bus.src1_rd_inc), 32'(pop && m_gid));
    if (r) begin
      sb.delete();
    end else begin
      if (bus.src0_rd_inc) begin
        check("pop_empty0", 32'(e0), 32'(0));
        if (!e0) sb.push_back(q0.pop_front());
        pulses++;
      end
      if (bus.src1_rd_inc) begin
        check("pop_empty1", 32'(e1), 32'(0));
        if (!e1) sb.push_back(q1.pop_front());
        pulses++;
      end
    end
  endtask

  logic [DW-1:0] exp_c[8] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hA4, 8'hA5};
  bit            exp_g[3] = '{1'b0, 1'b1, 1'b0};

  initial begin
    rst = 1'b1;
    bus.arb_en = 1'b0; bus.tx_ready = 1'b0;
    bus.src0_empty = 1'b1; bus.src1_empty = 1'b1;
    bus.src0_rd_data = '0; bus.src1_rd_data = '0;
    repeat (2) @(posedge clk);

    // Reset state, then two-source contention
    cycle(1'b1, 1'b0, 1'b0);
    q0 = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    q1 = '{8'hB0, 8'hB1};
    acc_log.delete(); glog.delete();
    repeat (24) cycle(1'b0, 1'b1, 1'b1);
    check("cont_len", 32'(acc_log.size()), 32'(8));
    for (int i = 0; i < 8; i++)
      if (i < acc_log.size()) check("cont_order", 32'(acc_log[i]), 32'(exp_c[i]));
    check("cont_grants", 32'(glog.size()), 32'(3));
    for (int i = 0; i < 3; i++)
      if (i < glog.size()) check("cont_grant_id", 32'(glog[i]), 32'(exp_g[i]));

    // Backpressure: stall five cycles after the first load
    cycle(1'b1, 1'b0, 1'b1);
    q0 = '{8'h11, 8'h22, 8'h33};
    acc_log.delete(); pulses = 0;
    repeat (2) cycle(1'b0, 1'b1, 1'b1);
    repeat (5) cycle(1'b0, 1'b1, 1'b0);
    check("bp_stall_pulses", 32'(pulses), 32'(1));
    repeat (6) cycle(1'b0, 1'b1, 1'b1);
    check("bp_accepted", 32'(acc_log.size()), 32'(3));
    check("bp_pulses", 32'(pulses), 32'(3));

    // Empty release on src1 with two words
    q1 = '{8'h51, 8'h52};
    pulses = 0;
    repeat (5) cycle(1'b0, 1'b1, 1'b1);
    check("er_pulses", 32'(pulses), 32'(2));

    // arb_en dropped in the second serve cycle
    cycle(1'b1, 1'b0, 1'b1);
    q0 = '{8'h61, 8'h62, 8'h63, 8'h64};
    pulses = 0; glog.delete();
    repeat (2) cycle(1'b0, 1'b1, 1'b1);
    repeat (6) cycle(1'b0, 1'b0, 1'b1);
    check("en_pulses", 32'(pulses), 32'(2));
    check("en_left", 32'(q0.size()), 32'(2));
    check("en_grants", 32'(glog.size()), 32'(1));
    repeat (4) cycle(1'b0, 1'b1, 1'b1);

    // Reset mid-burst, then contention goes to source 0
    q0 = '{8'h71, 8'h72, 8'h73, 8'h74, 8'h75, 8'h76};
    repeat (3) cycle(1'b0, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 1'b1);
    check("rst_fifo_kept", 32'(q0.size()), 32'(4));
    q1 = '{8'h81, 8'h82};
    glog.delete();
    repeat (3) cycle(1'b0, 1'b1, 1'b1);
    check("rst_grants", 32'(glog.size() != 0), 32'(1));
    if (glog.size() != 0) check("rst_first_grant", 32'(glog[0]), 32'(0));
    repeat (20) cycle(1'b0, 1'b1, 1'b1);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 2) == 0 && q0.size() < 7) q0.push_back(DW'($urandom_range(0, 255)));
      if ($urandom_range(0, 3) == 0 && q1.size() < 7) q1.push_back(DW'($urandom_range(0, 255)));
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0);
    end

    repeat (10) cycle(1'b0, 1'b0, 1'b1);
    check("drain_sb", 32'(sb.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
